// File: rtl/apb_i2c_regs.sv
// APB register front-end for an I2C master: CTRL/STATUS/SADDR/PRESCALE plus TX/RX byte FIFOs.
// Every APB transfer takes one wait state; full FIFOs drop pushes and raise sticky overflow flags.

module apb_i2c_regs_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic [W-1:0] dat_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic         full_o,
    output logic         empty_o,
    output logic         acc_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_pop  = pop_i & ~empty_o;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign acc_o   = push_i & (~full_o | do_pop);
    assign head_o  = mem_q[rptr_q];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (acc_o)  wptr_d = wptr_q + 1'b1;
            if (do_pop) rptr_d = rptr_q + 1'b1;
            if (acc_o && !do_pop)      cnt_d = cnt_q + 1'b1;
            else if (do_pop && !acc_o) cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (acc_o && !flush_i) mem_q[wptr_q] <= dat_i;
    end
endmodule

module apb_i2c_regs #(
    parameter int         TX_DEPTH     = 4,
    parameter int         RX_DEPTH     = 4,
    parameter logic [7:0] PRESCALE_RST = 8'd49
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       psel,
    input  logic       penable,
    input  logic       pwrite,
    input  logic [2:0] paddr,
    input  logic [7:0] pwdata,
    output logic [7:0] prdata,
    output logic       pready,
    output logic [7:0] tx_data_o,
    output logic       tx_valid_o,
    input  logic       tx_ready_i,
    input  logic [7:0] rx_data_i,
    input  logic       rx_valid_i,
    input  logic       nack_i,
    input  logic       busy_i,
    output logic       start_o,
    output logic       stop_o,
    output logic       rw_o,
    output logic       enable_o,
    output logic [6:0] slave_addr_o,
    output logic [7:0] prescale_o
);
    localparam logic [2:0] A_CTRL  = 3'd0;
    localparam logic [2:0] A_STAT  = 3'd1;
    localparam logic [2:0] A_SADDR = 3'd2;
    localparam logic [2:0] A_PRESC = 3'd3;
    localparam logic [2:0] A_TXD   = 3'd4;
    localparam logic [2:0] A_RXD   = 3'd5;

    logic       pready_q, pready_d;
    logic [7:0] prdata_q, prdata_d;
    logic       en_q, en_d, rw_q, rw_d;
    logic       start_q, start_d, stop_q, stop_d;
    logic [6:0] saddr_q, saddr_d;
    logic [7:0] presc_q, presc_d;
    logic       nack_q, nack_d, rx_ovf_q, rx_ovf_d, tx_ovf_q, tx_ovf_d;
    logic       rx_pend_q, rx_pend_d;

    logic       acc_rise, commit, wr_ctrl, wr_stat, flush;
    logic       tx_push, tx_pop, tx_acc, tx_full, tx_empty;
    logic       rx_pop, rx_acc, rx_full, rx_empty;
    logic [7:0] rx_head, rdata;

    assign acc_rise = psel & penable & ~pready_q;
    assign commit   = psel & penable & pready_q;
    assign wr_ctrl  = commit & pwrite & (paddr == A_CTRL);
    assign wr_stat  = commit & pwrite & (paddr == A_STAT);
    assign flush    = wr_ctrl & en_q & ~pwdata[0];
    assign tx_push  = commit & pwrite & (paddr == A_TXD);
    assign tx_pop   = tx_valid_o & tx_ready_i;
    // Pop decision is latched when the data is sampled, so a byte arriving
    // between sample and commit is never silently consumed.
    assign rx_pop   = commit & rx_pend_q;

    apb_i2c_regs_fifo #(.DEPTH(TX_DEPTH), .W(8)) u_tx_fifo (
        .clk_i(clk_i), .rst_i(reset_i), .flush_i(flush),
        .push_i(tx_push), .dat_i(pwdata), .pop_i(tx_pop),
        .head_o(tx_data_o), .full_o(tx_full), .empty_o(tx_empty), .acc_o(tx_acc)
    );

    apb_i2c_regs_fifo #(.DEPTH(RX_DEPTH), .W(8)) u_rx_fifo (
        .clk_i(clk_i), .rst_i(reset_i), .flush_i(flush),
        .push_i(rx_valid_i), .dat_i(rx_data_i), .pop_i(rx_pop),
        .head_o(rx_head), .full_o(rx_full), .empty_o(rx_empty), .acc_o(rx_acc)
    );

    always_comb begin
        rdata = 8'h00;
        case (paddr)
            A_CTRL:  rdata = {4'b0, rw_q, 2'b0, en_q};
            A_STAT:  rdata = {tx_ovf_q, rx_ovf_q, nack_q, rx_full, rx_empty,
                              tx_empty, tx_full, busy_i};
            A_SADDR: rdata = {1'b0, saddr_q};
            A_PRESC: rdata = presc_q;
            A_RXD:   rdata = rx_empty ? 8'h00 : rx_head;
            default: rdata = 8'h00;
        endcase
    end

    always_comb begin
        pready_d  = acc_rise;
        prdata_d  = prdata_q;
        rx_pend_d = acc_rise & ~pwrite & (paddr == A_RXD) & ~rx_empty;
        en_d      = en_q;
        rw_d      = rw_q;
        start_d   = 1'b0;
        stop_d    = 1'b0;
        saddr_d   = saddr_q;
        presc_d   = presc_q;
        if (acc_rise && !pwrite) prdata_d = rdata;
        if (wr_ctrl) begin
            en_d    = pwdata[0];
            rw_d    = pwdata[3];
            start_d = pwdata[1] & pwdata[0];
            stop_d  = pwdata[2] & pwdata[0];
        end
        if (commit && pwrite && paddr == A_SADDR) saddr_d = pwdata[6:0];
        if (commit && pwrite && paddr == A_PRESC) presc_d = pwdata;
        // Sticky flags: a new event in the clearing cycle keeps the flag set.
        nack_d   = (nack_q   & ~(wr_stat & pwdata[5])) | nack_i;
        rx_ovf_d = (rx_ovf_q & ~(wr_stat & pwdata[6])) | (rx_valid_i & ~rx_acc & ~flush);
        tx_ovf_d = (tx_ovf_q & ~(wr_stat & pwdata[7])) | (tx_push & ~tx_acc);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pready_q  <= 1'b0;
            prdata_q  <= 8'h00;
            rx_pend_q <= 1'b0;
            en_q      <= 1'b0;
            rw_q      <= 1'b0;
            start_q   <= 1'b0;
            stop_q    <= 1'b0;
            saddr_q   <= 7'h00;
            presc_q   <= PRESCALE_RST;
            nack_q    <= 1'b0;
            rx_ovf_q  <= 1'b0;
            tx_ovf_q  <= 1'b0;
        end else begin
            pready_q  <= pready_d;
            prdata_q  <= prdata_d;
            rx_pend_q <= rx_pend_d;
            en_q      <= en_d;
            rw_q      <= rw_d;
            start_q   <= start_d;
            stop_q    <= stop_d;
            saddr_q   <= saddr_d;
            presc_q   <= presc_d;
            nack_q    <= nack_d;
            rx_ovf_q  <= rx_ovf_d;
            tx_ovf_q  <= tx_ovf_d;
        end
    end

    assign pready       = pready_q;
    assign prdata       = prdata_q;
    assign tx_valid_o   = ~tx_empty;
    assign start_o      = start_q;
    assign stop_o       = stop_q;
    assign rw_o         = rw_q;
    assign enable_o     = en_q;
    assign slave_addr_o = saddr_q;
    assign prescale_o   = presc_q;
endmodule

// File: tb/tb_apb_i2c_regs.sv
// Directed bench for apb_i2c_regs: read data and TX bytes are checked by scoreboard monitors.
module tb_apb_i2c_regs;
    logic       clk_i = 1'b0;
    logic       reset_i = 1'b1;
    logic       psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [2:0] paddr = 3'd0;
    logic [7:0] pwdata = 8'h00;
    logic [7:0] prdata;
    logic       pready;
    logic [7:0] tx_data_o;
    logic       tx_valid_o;
    logic       tx_ready_i = 1'b0;
    logic [7:0] rx_data_i = 8'h00;
    logic       rx_valid_i = 1'b0, nack_i = 1'b0, busy_i = 1'b0;
    logic       start_o, stop_o, rw_o, enable_o;
    logic [6:0] slave_addr_o;
    logic [7:0] prescale_o;

    int tests = 0;
    int fails = 0;
    logic [7:0] rd_q[$];
    logic [7:0] tx_q[$];

    apb_i2c_regs dut (
        .clk_i(clk_i), .reset_i(reset_i), .psel(psel), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
        .pready(pready), .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o),
        .tx_ready_i(tx_ready_i), .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i),
        .nack_i(nack_i), .busy_i(busy_i), .start_o(start_o), .stop_o(stop_o),
        .rw_o(rw_o), .enable_o(enable_o), .slave_addr_o(slave_addr_o),
        .prescale_o(prescale_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (psel && penable && pready && !pwrite) begin
            if (rd_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL rd_unexpected: addr %0d read %0h, no read was expected", paddr, prdata);
            end else begin
                chk($sformatf("rd_addr%0d", paddr), prdata, rd_q.pop_front());
            end
        end
    end

    always @(negedge clk_i) begin
        if (tx_valid_o && tx_ready_i) begin
            if (tx_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL tx_unexpected: got byte %0h, no byte was expected", tx_data_o);
            end else begin
                chk("tx_byte", tx_data_o, tx_q.pop_front());
            end
        end
    end

    task automatic apb(input logic w, input logic [2:0] a, input logic [7:0] d,
                       input logic nack_at_commit, output int lat);
        @(posedge clk_i); #1;
        psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
        @(posedge clk_i); #1;
        penable = 1'b1;
        lat = 0;
        while (!pready && lat < 8) begin
            @(posedge clk_i); #1;
            lat++;
        end
        if (!pready) begin
            tests++;
            fails++;
            $display("FAIL apb_timeout: addr %0d got no pready, expected pready within 8 cycles", a);
        end
        nack_i = nack_at_commit;
        @(posedge clk_i); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; nack_i = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        int l;
        apb(1'b1, a, d, 1'b0, l);
    endtask

    task automatic rd(input logic [2:0] a, input logic [7:0] e);
        int l;
        rd_q.push_back(e);
        apb(1'b0, a, 8'h00, 1'b0, l);
    endtask

    task automatic rx_push(input logic [7:0] d);
        @(posedge clk_i); #1;
        rx_valid_i = 1'b1; rx_data_i = d;
        @(posedge clk_i); #1;
        rx_valid_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int n;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_prdata", prdata, 8'h00);
        chk("rst_pready", pready, 1'b0);
        chk("rst_prescale", prescale_o, 8'd49);
        chk("rst_start", start_o, 1'b0);
        chk("rst_stop", stop_o, 1'b0);
        chk("rst_enable", enable_o, 1'b0);
        chk("rst_saddr", slave_addr_o, 7'h00);
        chk("rst_tx_valid", tx_valid_o, 1'b0);
        reset_i = 1'b0;

        rd(3'd3, 8'h31);
        rd(3'd1, 8'h0C);

        // EN|START|RW
        apb(1'b1, 3'd0, 8'h0B, 1'b0, lat);
        chk("ctrl_pready_lat", lat, 1);
        chk("start_pulse", start_o, 1'b1);
        chk("stop_idle", stop_o, 1'b0);
        chk("rw_level", rw_o, 1'b1);
        chk("en_level", enable_o, 1'b1);
        @(posedge clk_i); #1;
        chk("start_selfclr", start_o, 1'b0);
        rd(3'd0, 8'h09);

        wr(3'd2, 8'hD5);
        chk("saddr_out", slave_addr_o, 7'h55);
        rd(3'd2, 8'h55);
        wr(3'd3, 8'h07);
        chk("prescale_out", prescale_o, 8'h07);

        for (int i = 0; i < 5; i++) wr(3'd4, 8'h11 + 8'(i));
        rd(3'd1, 8'h8A);
        for (int i = 0; i < 4; i++) tx_q.push_back(8'h11 + 8'(i));
        tx_ready_i = 1'b1;
        n = 0;
        while (tx_valid_o && n < 20) begin
            @(posedge clk_i); #1;
            n++;
        end
        tx_ready_i = 1'b0;
        chk("tx_left_over", tx_q.size(), 0);
        wr(3'd1, 8'h80);
        rd(3'd1, 8'h0C);
        rd(3'd4, 8'h00);

        rx_push(8'hA5);
        rd(3'd5, 8'hA5);
        rd(3'd1, 8'h0C);
        rd(3'd5, 8'h00);

        @(posedge clk_i); #1; nack_i = 1'b1;
        @(posedge clk_i); #1; nack_i = 1'b0;
        rd(3'd1, 8'h2C);
        wr(3'd1, 8'h20);
        rd(3'd1, 8'h0C);
        @(posedge clk_i); #1; nack_i = 1'b1;
        @(posedge clk_i); #1; nack_i = 1'b0;
        apb(1'b1, 3'd1, 8'h20, 1'b1, lat);
        rd(3'd1, 8'h2C);
        wr(3'd1, 8'h20);
        busy_i = 1'b1;
        rd(3'd1, 8'h0D);
        busy_i = 1'b0;

        wr(3'd4, 8'h33);
        wr(3'd4, 8'h44);
        rx_push(8'h66);
        rd(3'd1, 8'h00);
        // START with EN=0: no pulse, and the EN fall flushes both FIFOs
        wr(3'd0, 8'h02);
        chk("start_en0", start_o, 1'b0);
        chk("en_cleared", enable_o, 1'b0);
        chk("tx_flushed", tx_valid_o, 1'b0);
        @(posedge clk_i); #1;
        chk("start_en0_late", start_o, 1'b0);
        rd(3'd1, 8'h0C);

        wr(3'd0, 8'h05);
        chk("stop_pulse", stop_o, 1'b1);
        chk("start_with_stop", start_o, 1'b0);
        chk("rw_cleared", rw_o, 1'b0);
        for (int i = 0; i < 5; i++) rx_push(8'hC0 + 8'(i));
        rd(3'd1, 8'h54);
        rd(3'd5, 8'hC0);
        wr(3'd0, 8'h00);
        rd(3'd1, 8'h4C);

        wr(3'd7, 8'hFF);
        rd(3'd6, 8'h00);
        rd(3'd7, 8'h00);

        rd(3'd2, 8'h55);
        @(posedge clk_i); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 3'd3;
        @(posedge clk_i); #1;
        penable = 1'b1;
        chk("prdata_pre_rst", prdata, 8'h55);
        #2 reset_i = 1'b1;
        #1;
        chk("midrst_pready", pready, 1'b0);
        chk("midrst_prdata", prdata, 8'h00);
        chk("midrst_prescale", prescale_o, 8'd49);
        @(posedge clk_i); #1;
        psel = 1'b0; penable = 1'b0;
        reset_i = 1'b0;
        rd(3'd3, 8'h31);
        rd(3'd1, 8'h0C);
        rd(3'd2, 8'h00);

        repeat (3) @(posedge clk_i);
        #1;
        chk("rd_left_over", rd_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
